// File: rtl/mips_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with the architectural HI/LO registers; MTHI/MTLO write on the accept edge.
// Latency: MUL/DIV busy for WIDTH+1 enabled cycles, with HI/LO written and done pulsed on the final edge; MTHI/MTLO take effect on the accept edge.
// Backpressure: op_ready is low while busy; the requester holds op_valid and operands until an edge with en & op_valid & op_ready.
module mips_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_x,
    input  logic [WIDTH-1:0] op_y,
    output logic             op_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;        // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
    logic [WIDTH-1:0]     mag_y;
    logic [WIDTH-1:0]     orig_x;
    logic                 neg_res;    // product / quotient must be negated
    logic                 neg_rem;    // remainder follows the dividend's sign
    logic                 is_div;

    logic                 accept;
    logic                 sgn_op, x_neg, y_neg;
    logic [WIDTH-1:0]     mag_x_in, mag_y_in;
    logic [WIDTH:0]       mul_add, mul_sum;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     q_fix, r_fix;

    // Operand conditioning and per-iteration arithmetic
    always_comb begin
        accept   = en & op_valid & op_ready;
        sgn_op   = ~op[0];
        x_neg    = sgn_op & op_x[WIDTH-1];
        y_neg    = sgn_op & op_y[WIDTH-1];
        mag_x_in = x_neg ? -op_x : op_x;
        mag_y_in = y_neg ? -op_y : op_y;
        mul_add  = acc[0] ? {1'b0, mag_y} : '0;
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + mul_add;
        div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mag_y};
        prod_fix = neg_res ? -acc : acc;
        q_fix    = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        r_fix    = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        op_ready  = 1'b0;
        case (state)
            IDLE: begin
                op_ready = 1'b1;
                if (accept) begin
                    if (op == 3'd0 || op == 3'd1)      state_nxt = MUL;
                    else if (op == 3'd2 || op == 3'd3) state_nxt = DIV;
                end
            end
            MUL, DIV: begin
                busy = 1'b1;
                if (en && cnt == CNT_W'(1)) state_nxt = FIX;
            end
            FIX: begin
                busy = 1'b1;
                if (en) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand latch, one iteration per enabled cycle, sign fix-up and HI/LO commit
    always_ff @(posedge clk) begin
        if (rst) begin
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            mag_y   <= '0;
            orig_x  <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            is_div  <= 1'b0;
        end else begin
            done <= en && (state == FIX);
            if (en) begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            case (op)
                                3'd0, 3'd1, 3'd2, 3'd3: begin
                                    acc     <= {{WIDTH{1'b0}}, mag_x_in};
                                    mag_y   <= mag_y_in;
                                    orig_x  <= op_x;
                                    neg_res <= x_neg ^ y_neg;
                                    neg_rem <= x_neg;
                                    is_div  <= op[1];
                                    cnt     <= CNT_W'(WIDTH);
                                end
                                3'd4:    hi <= op_x;
                                3'd5:    lo <= op_x;
                                default: ;
                            endcase
                        end
                    end
                    MUL: begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                        cnt <= cnt - CNT_W'(1);
                    end
                    DIV: begin
                        if (!div_diff[WIDTH]) acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                        else                  acc <= {acc[2*WIDTH-2:0], 1'b0};
                        cnt <= cnt - CNT_W'(1);
                    end
                    FIX: begin
                        // Divide by zero returns all-ones quotient and the raw dividend, unsigned
                        if (is_div && mag_y == '0) begin
                            hi <= orig_x;
                            lo <= '1;
                        end else if (is_div) begin
                            hi <= r_fix;
                            lo <= q_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mips_muldiv.sv
// Directed bench for mips_muldiv at WIDTH=32, plus a WIDTH=8 instance checked against a behavioural model.
// Inputs are driven #1 after the rising edge; outputs are sampled at the same point.
// Every wait for done is bounded so the run always reaches its summary line.
module tb_mips_muldiv;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;

    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] op_x = '0, op_y = '0;
    logic        op_ready, busy, done;
    logic [31:0] hi, lo;

    logic        op_valid8 = 1'b0;
    logic [2:0]  op8 = 3'd0;
    logic [7:0]  x8 = '0, y8 = '0;
    logic        op_ready8, busy8, done8;
    logic [7:0]  hi8, lo8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mips_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .en(en), .op_valid(op_valid), .op(op),
        .op_x(op_x), .op_y(op_y), .op_ready(op_ready), .busy(busy),
        .done(done), .hi(hi), .lo(lo)
    );

    mips_muldiv #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .op_valid(op_valid8), .op(op8),
        .op_x(x8), .op_y(y8), .op_ready(op_ready8), .busy(busy8),
        .done(done8), .hi(hi8), .lo(lo8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue32(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; op_x = a; op_y = b; op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
    endtask

    task automatic wait_done32(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!done && cyc < 100);
    endtask

    task automatic run32(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int cyc;
        issue32(o, a, b);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s busy after accept: got %b want 1", name, busy); end
        wait_done32(cyc);
        checks++;
        if (cyc !== 33) begin errors++; $display("FAIL %s latency: got %0d want 33", name, cyc); end
        checks++;
        if (hi !== eh) begin errors++; $display("FAIL %s hi: got %h want %h", name, hi, eh); end
        checks++;
        if (lo !== el) begin errors++; $display("FAIL %s lo: got %h want %h", name, lo, el); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s busy at done: got %b want 0", name, busy); end
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL %s done pulse width: got %b want 0", name, done); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL reset hi/lo: got %h/%h want 0/0", hi, lo); end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || op_ready !== 1'b1) begin
            errors++; $display("FAIL reset flags busy/done/ready: got %b%b%b want 001", busy, done, op_ready);
        end
    endtask

    task automatic test_mult();
        run32("mult_neg1x2",   3'd0, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run32("multu_max_x2",  3'd1, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE);
        run32("mult_min_sq",   3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    endtask

    task automatic test_div();
        run32("div_m7_2",      3'd2, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run32("divu_7_2",      3'd3, 32'h7, 32'h2, 32'h1, 32'h3);
        run32("divu_by_zero",  3'd3, 32'h7, 32'h0, 32'h7, 32'hFFFFFFFF);
        run32("div_neg_by_0",  3'd2, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF);
        run32("div_min_m1",    3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] lo_before;
        lo_before = lo;
        op = 3'd4; op_x = 32'h12345678; op_y = '0; op_valid = 1'b1;
        tick();
        checks++;
        if (hi !== 32'h12345678) begin errors++; $display("FAIL mthi hi: got %h want 12345678", hi); end
        checks++;
        if (lo !== lo_before) begin errors++; $display("FAIL mthi lo disturbed: got %h want %h", lo, lo_before); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL mthi busy: got %b want 0", busy); end
        op = 3'd5; op_x = 32'h9ABCDEF0;
        tick();
        op_valid = 1'b0;
        checks++;
        if (lo !== 32'h9ABCDEF0) begin errors++; $display("FAIL mtlo lo: got %h want 9abcdef0", lo); end
        checks++;
        if (hi !== 32'h12345678) begin errors++; $display("FAIL mtlo hi disturbed: got %h want 12345678", hi); end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mtlo busy/done: got %b%b want 00", busy, done); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        op = 3'd0; op_x = 32'd3; op_y = 32'd5; op_valid = 1'b1;
        tick();
        op = 3'd1; op_x = 32'd6; op_y = 32'd7;
        wait_done32(cyc);
        checks++;
        if (cyc !== 33) begin errors++; $display("FAIL b2b first latency: got %0d want 33", cyc); end
        checks++;
        if (lo !== 32'd15 || hi !== 32'd0) begin errors++; $display("FAIL b2b first result: got %h_%h want 0_f", hi, lo); end
        checks++;
        if (op_ready !== 1'b1) begin errors++; $display("FAIL b2b ready at done: got %b want 1", op_ready); end
        tick();
        op_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b second accept busy: got %b want 1", busy); end
        wait_done32(cyc);
        checks++;
        if (cyc !== 33) begin errors++; $display("FAIL b2b second latency: got %0d want 33", cyc); end
        checks++;
        if (lo !== 32'd42 || hi !== 32'd0) begin errors++; $display("FAIL b2b second result: got %h_%h want 0_2a", hi, lo); end
        tick();
    endtask

    task automatic test_enable_stall();
        int cyc;
        logic seen;
        issue32(3'd3, 32'd100, 32'd7);
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            tick();
            cyc++;
            if (cyc == 10) en = 1'b0;
            if (cyc == 12) begin
                checks++;
                if (busy !== 1'b1 || hi !== 32'd0 || lo !== 32'd42) begin
                    errors++; $display("FAIL stall hold: got busy=%b hi=%h lo=%h want 1/0/2a", busy, hi, lo);
                end
            end
            if (cyc == 15) en = 1'b1;
            seen = done;
        end
        checks++;
        if (cyc !== 38) begin errors++; $display("FAIL stall latency: got %0d want 38", cyc); end
        checks++;
        if (lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL stall result: got %h_%h want 2_e", hi, lo); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic fired;
        issue32(3'd0, 32'h11111111, 32'h3);
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++; $display("FAIL reset mid-op: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
        end
        fired = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) fired = 1'b1;
        end
        checks++;
        if (fired !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++; $display("FAIL reset abort: got done_seen=%b hi=%h lo=%h want 0/0/0", fired, hi, lo);
        end
    endtask

    function automatic void model8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                                   output logic [7:0] h, output logic [7:0] l);
        int sa, sb, p, q, r;
        sa = o[0] ? int'(a) : int'($signed(a));
        sb = o[0] ? int'(b) : int'($signed(b));
        h = '0;
        l = '0;
        if (!o[1]) begin
            p = sa * sb;
            h = p[15:8];
            l = p[7:0];
        end else if (b == 8'h0) begin
            h = a;
            l = 8'hFF;
        end else begin
            q = sa / sb;
            r = sa % sb;
            h = r[7:0];
            l = q[7:0];
        end
    endfunction

    task automatic test_width8();
        logic [2:0] o;
        logic [7:0] a, b, eh, el;
        int cyc;
        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom_range(0, 3));
            a = 8'($urandom);
            b = 8'($urandom);
            if (i == 0) begin o = 3'd2; a = 8'h80; b = 8'hFF; end
            if (i == 1) begin o = 3'd3; a = 8'h55; b = 8'h00; end
            if (i == 2) begin o = 3'd0; a = 8'h80; b = 8'h80; end
            if (i == 3) begin o = 3'd2; a = 8'hF3; b = 8'h04; end
            model8(o, a, b, eh, el);
            op8 = o; x8 = a; y8 = b; op_valid8 = 1'b1;
            tick();
            op_valid8 = 1'b0;
            cyc = 0;
            do begin
                tick();
                cyc++;
            end while (!done8 && cyc < 40);
            checks++;
            if (cyc !== 9) begin errors++; $display("FAIL w8[%0d] latency: got %0d want 9", i, cyc); end
            checks++;
            if (hi8 !== eh || lo8 !== el) begin
                errors++; $display("FAIL w8[%0d] op=%0d %h,%h: got %h_%h want %h_%h", i, o, a, b, hi8, lo8, eh, el);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_back_to_back();
        test_enable_stall();
        test_reset_mid();
        test_width8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
